// File: rtl/dcache_port_arbiter_if.sv
// Bundles the LSU load pipe, write-buffer drain and cache accessor signals.
// Pure wiring, no latency of its own.
// Backpressure travels as ld_gnt/st_gnt toward requesters and da_ready from the cache.
interface dcache_port_arbiter_if;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [6:0]  ld_id;
  logic        ld_gnt;
  logic        ld_done;
  logic [6:0]  ld_done_id;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_gnt;
  logic        st_done;
  logic        flush;
  logic        da_req;
  logic        da_we;
  logic [31:0] da_addr;
  logic [31:0] da_wdata;
  logic [1:0]  da_size;
  logic        da_ready;
  logic        busy;

  // Requester and cache side: drives requests, flush and da_ready.
  modport master (
    output ld_req, ld_addr, ld_id, st_req, st_addr, st_data, st_size, flush, da_ready,
    input  ld_gnt, ld_done, ld_done_id, st_gnt, st_done,
    input  da_req, da_we, da_addr, da_wdata, da_size, busy
  );

  // Arbiter side.
  modport slave (
    input  ld_req, ld_addr, ld_id, st_req, st_addr, st_data, st_size, flush, da_ready,
    output ld_gnt, ld_done, ld_done_id, st_gnt, st_done,
    output da_req, da_we, da_addr, da_wdata, da_size, busy
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Shares the single data-cache port between the load pipe and the store drain.
// Grant is combinational; da_* registered one edge after grant; done pulses one edge after da_ready.
// A granted request is held on the port until da_ready; new grants only while idle or on da_ready.
module dcache_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  resetn,
  dcache_port_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_BUSY = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        da_req_q, da_req_d;
  logic        da_we_q, da_we_d;
  logic [31:0] da_addr_q, da_addr_d;
  logic [31:0] da_wdata_q, da_wdata_d;
  logic [1:0]  da_size_q, da_size_d;
  logic [6:0]  ld_id_q, ld_id_d;
  logic        kill_q, kill_d;
  logic        ld_done_q, ld_done_d;
  logic [6:0]  ld_done_id_q, ld_done_id_d;
  logic        st_done_q, st_done_d;
  logic [3:0]  starve_q, starve_d;

  logic window;
  logic same_line;
  logic st_win;
  logic ld_win;

  // Arbitration: loads win unless the store shares their line, is starved, or a flush is in flight.
  always_comb begin
    window    = (state_q == IDLE) || bus.da_ready;
    same_line = (bus.ld_addr[31:4] == bus.st_addr[31:4]);
    st_win    = window && bus.st_req &&
                (!bus.ld_req || same_line || (starve_q == LIMIT) || bus.flush);
    ld_win    = window && !st_win && bus.ld_req && !bus.flush;
  end

  // Next-state and port-register update; old done and new grant can land on the same edge.
  always_comb begin
    state_d      = state_q;
    da_req_d     = da_req_q;
    da_we_d      = da_we_q;
    da_addr_d    = da_addr_q;
    da_wdata_d   = da_wdata_q;
    da_size_d    = da_size_q;
    ld_id_d      = ld_id_q;
    kill_d       = kill_q;
    ld_done_d    = 1'b0;
    ld_done_id_d = ld_done_id_q;
    st_done_d    = 1'b0;
    starve_d     = starve_q;

    case (state_q)
      LD_BUSY: begin
        if (bus.da_ready) begin
          // A flush coinciding with acceptance still kills the response.
          ld_done_d    = !kill_q && !bus.flush;
          ld_done_id_d = ld_id_q;
        end else if (bus.flush) begin
          // The cache cannot see a withdrawn request, so keep it up and just drop the response.
          kill_d = 1'b1;
        end
      end
      ST_BUSY: begin
        st_done_d = bus.da_ready;
      end
      default: ;
    endcase

    if (st_win) begin
      state_d    = ST_BUSY;
      da_req_d   = 1'b1;
      da_we_d    = 1'b1;
      da_addr_d  = bus.st_addr;
      da_wdata_d = bus.st_data;
      da_size_d  = bus.st_size;
    end else if (ld_win) begin
      state_d   = LD_BUSY;
      da_req_d  = 1'b1;
      da_we_d   = 1'b0;
      da_addr_d = bus.ld_addr;
      da_size_d = 2'b10;
      ld_id_d   = bus.ld_id;
      kill_d    = 1'b0;
    end else if ((state_q != IDLE) && bus.da_ready) begin
      state_d  = IDLE;
      da_req_d = 1'b0;
    end

    if (bus.st_req && !st_win) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
    end else begin
      starve_d = 4'd0;
    end
  end

  // State and port registers; reset drops any transaction in flight without a done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      da_req_q     <= 1'b0;
      da_we_q      <= 1'b0;
      da_addr_q    <= '0;
      da_wdata_q   <= '0;
      da_size_q    <= '0;
      ld_id_q      <= '0;
      kill_q       <= 1'b0;
      ld_done_q    <= 1'b0;
      ld_done_id_q <= '0;
      st_done_q    <= 1'b0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      da_req_q     <= da_req_d;
      da_we_q      <= da_we_d;
      da_addr_q    <= da_addr_d;
      da_wdata_q   <= da_wdata_d;
      da_size_q    <= da_size_d;
      ld_id_q      <= ld_id_d;
      kill_q       <= kill_d;
      ld_done_q    <= ld_done_d;
      ld_done_id_q <= ld_done_id_d;
      st_done_q    <= st_done_d;
      starve_q     <= starve_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.ld_gnt     = ld_win;
    bus.st_gnt     = st_win;
    bus.ld_done    = ld_done_q;
    bus.ld_done_id = ld_done_id_q;
    bus.st_done    = st_done_q;
    bus.da_req     = da_req_q;
    bus.da_we      = da_we_q;
    bus.da_addr    = da_addr_q;
    bus.da_wdata   = da_wdata_q;
    bus.da_size    = da_size_q;
    bus.busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Randomized and directed stimulus for the data-cache port arbiter.
// Outputs are compared each falling edge against a transaction-level reference model.
// Covers reset, line-hit priority, starvation, flush kill and asynchronous reset mid-store.
module tb_dcache_port_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dcache_port_arbiter_if bus();

  dcache_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Reference model: the transaction currently occupying the port, plus pending done pulses.
  bit          m_occ;
  bit          m_is_st;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_size;
  logic [6:0]  m_id;
  bit          m_killed;
  bit          m_ld_done;
  logic [6:0]  m_ld_done_id;
  bit          m_st_done;
  int          m_starve;
  bit          obs_ld_gnt, obs_st_gnt;

  task automatic model_reset();
    m_occ = 0; m_is_st = 0; m_addr = '0; m_data = '0; m_size = '0; m_id = '0;
    m_killed = 0; m_ld_done = 0; m_ld_done_id = '0; m_st_done = 0; m_starve = 0;
  endtask

  task automatic drive_idle();
    bus.ld_req = 0; bus.ld_addr = '0; bus.ld_id = '0;
    bus.st_req = 0; bus.st_addr = '0; bus.st_data = '0; bus.st_size = '0;
    bus.flush = 0; bus.da_ready = 0;
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    bit win, e_st, e_ld, hit;
    @(negedge clk);
    hit  = (bus.ld_addr >> 4) == (bus.st_addr >> 4);
    win  = !m_occ || bus.da_ready;
    e_st = win && bus.st_req && (!bus.ld_req || hit || m_starve == LIMIT || bus.flush);
    e_ld = win && !e_st && bus.ld_req && !bus.flush;
    obs_ld_gnt = bus.ld_gnt;
    obs_st_gnt = bus.st_gnt;
    chk("ld_gnt", 32'(bus.ld_gnt), 32'(e_ld));
    chk("st_gnt", 32'(bus.st_gnt), 32'(e_st));
    chk("da_req", 32'(bus.da_req), 32'(m_occ));
    chk("busy", 32'(bus.busy), 32'(m_occ));
    chk("ld_done", 32'(bus.ld_done), 32'(m_ld_done));
    chk("st_done", 32'(bus.st_done), 32'(m_st_done));
    if (m_ld_done) chk("ld_done_id", 32'(bus.ld_done_id), 32'(m_ld_done_id));
    if (m_occ) begin
      chk("da_we", 32'(bus.da_we), 32'(m_is_st));
      chk("da_addr", bus.da_addr, m_addr);
      chk("da_size", 32'(bus.da_size), 32'(m_size));
      if (m_is_st) chk("da_wdata", bus.da_wdata, m_data);
    end
    // Completion of the current occupant.
    m_ld_done = m_occ && !m_is_st && bus.da_ready && !m_killed && !bus.flush;
    m_ld_done_id = m_id;
    m_st_done = m_occ && m_is_st && bus.da_ready;
    if (m_occ && !m_is_st && !bus.da_ready && bus.flush) m_killed = 1;
    // Hand-over to the new winner.
    if (e_st) begin
      m_occ = 1; m_is_st = 1; m_addr = bus.st_addr; m_data = bus.st_data; m_size = bus.st_size;
    end else if (e_ld) begin
      m_occ = 1; m_is_st = 0; m_addr = bus.ld_addr; m_size = 2'b10; m_id = bus.ld_id; m_killed = 0;
    end else if (m_occ && bus.da_ready) begin
      m_occ = 0;
    end
    if (bus.st_req && !e_st) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
    else m_starve = 0;
    @(posedge clk);
    #1;
  endtask

  int first_st;

  initial begin
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_da_req", 32'(bus.da_req), 32'd0);
    chk("rst_da_we", 32'(bus.da_we), 32'd0);
    chk("rst_da_addr", bus.da_addr, 32'd0);
    chk("rst_da_wdata", bus.da_wdata, 32'd0);
    chk("rst_da_size", 32'(bus.da_size), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ld_done", 32'(bus.ld_done), 32'd0);
    chk("rst_st_done", 32'(bus.st_done), 32'd0);
    @(posedge clk); #1;
    resetn = 1;
    step();

    // Single load, accepted on the second busy cycle.
    bus.ld_req = 1; bus.ld_addr = 32'h1000; bus.ld_id = 7'd5;
    step();
    bus.ld_req = 0;
    step();
    bus.da_ready = 1;
    step();
    bus.da_ready = 0;
    step();
    step();

    // Load and store together on different lines, cache always ready.
    bus.da_ready = 1;
    bus.ld_req = 1; bus.ld_addr = 32'h3000; bus.ld_id = 7'd9;
    bus.st_req = 1; bus.st_addr = 32'h2004; bus.st_data = 32'hDEADBEEF; bus.st_size = 2'b10;
    step();
    chk("order_ld_first", 32'(obs_ld_gnt), 32'd1);
    bus.ld_req = 0;
    step();
    chk("order_st_next", 32'(obs_st_gnt), 32'd1);
    bus.st_req = 0;
    step();
    step();

    // Same line: store wins, load follows on the store's acceptance.
    bus.da_ready = 0;
    bus.ld_req = 1; bus.ld_addr = 32'h2008; bus.ld_id = 7'd12;
    bus.st_req = 1; bus.st_addr = 32'h2000; bus.st_data = 32'h12345678; bus.st_size = 2'b01;
    step();
    chk("line_hit_st", 32'(obs_st_gnt), 32'd1);
    bus.st_req = 0;
    step();
    bus.da_ready = 1;
    step();
    chk("line_hit_ld_after", 32'(obs_ld_gnt), 32'd1);
    bus.ld_req = 0;
    step();
    step();

    // Starvation: continuous loads on other lines, store must win on its 5th cycle.
    first_st = -1;
    bus.da_ready = 1;
    bus.st_req = 1; bus.st_addr = 32'h5000; bus.st_data = 32'hCAFEF00D; bus.st_size = 2'b10;
    bus.ld_req = 1;
    for (int i = 0; i < 9; i++) begin
      bus.ld_addr = 32'h8000 + 32'(i) * 32'h100; bus.ld_id = 7'(i);
      step();
      if (obs_st_gnt && first_st < 0) begin
        first_st = i;
        bus.st_req = 0;
      end
    end
    chk("starve_win_cycle", 32'(first_st), 32'(LIMIT));
    bus.ld_req = 0;
    step();

    // Flush while a load waits: request held, response dropped.
    bus.da_ready = 0;
    bus.ld_req = 1; bus.ld_addr = 32'h6000; bus.ld_id = 7'd33;
    step();
    bus.ld_req = 0; bus.flush = 1;
    step();
    bus.flush = 0;
    step();
    step();
    bus.da_ready = 1;
    step();
    bus.da_ready = 0;
    step();
    chk("flush_no_ld_done", 32'(bus.ld_done), 32'd0);
    // Flush during a store has no effect.
    bus.st_req = 1; bus.st_addr = 32'h7000; bus.st_data = 32'h0BADF00D; bus.st_size = 2'b00;
    step();
    bus.st_req = 0; bus.flush = 1;
    step();
    bus.flush = 0; bus.da_ready = 1;
    step();
    bus.da_ready = 0;
    step();

    // Asynchronous reset while a store occupies the port.
    bus.st_req = 1; bus.st_addr = 32'h9000; bus.st_data = 32'h55AA55AA; bus.st_size = 2'b10;
    step();
    bus.st_req = 0;
    step();
    #2;
    resetn = 0;
    #1;
    chk("async_rst_da_req", 32'(bus.da_req), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    drive_idle();
    model_reset();
    @(posedge clk); #1;
    bus.da_ready = 1;
    @(posedge clk); #1;
    resetn = 1;
    step();
    step();
    bus.da_ready = 0;

    // Randomized traffic; the store drain holds its request until granted.
    for (int i = 0; i < 2000; i++) begin
      if (bus.st_req == 0 || obs_st_gnt) begin
        bus.st_req  = ($urandom_range(0, 1) == 1);
        bus.st_addr = 32'h4000 + 32'($urandom_range(0, 3)) * 16 + 32'($urandom_range(0, 15));
        bus.st_data = $urandom;
        bus.st_size = 2'($urandom_range(0, 3));
      end
      bus.ld_req   = ($urandom_range(0, 9) < 7);
      bus.ld_addr  = 32'h4000 + 32'($urandom_range(0, 3)) * 16 + 32'($urandom_range(0, 15));
      bus.ld_id    = 7'($urandom);
      bus.flush    = ($urandom_range(0, 9) == 0);
      bus.da_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
